// File: rtl/afifo_rd_burst_ctrl_pkg.sv
// Shared types and default sizing for the async FIFO read-side burst sequencer.
package afifo_ctrl_pkg;

  typedef enum logic [1:0] {IDLE, BURST, DRAIN} state_t;

  localparam int DATA_W_DEF      = 16;
  localparam int LVL_W_DEF       = 15;
  localparam int BURST_LEN_DEF   = 256;
  localparam int TIMEOUT_CYC_DEF = 1024;

  localparam int CNT_W = $clog2(BURST_LEN_DEF + 1);
  localparam int TMO_W = $clog2(TIMEOUT_CYC_DEF + 1);

endpackage

// File: rtl/afifo_rd_burst_ctrl_if.sv
// FIFO read port plus downstream valid/ready stream seen by the burst sequencer.
interface afifo_rd_burst_ctrl_if
  import afifo_ctrl_pkg::*;
#(
  parameter int DATA_W = DATA_W_DEF,
  parameter int LVL_W  = LVL_W_DEF
);
  logic              fifo_rd_en;
  logic [DATA_W-1:0] fifo_rd_data;
  logic              fifo_rd_empty;
  logic [LVL_W-1:0]  fifo_rd_water_level;
  logic              m_valid;
  logic              m_ready;
  logic [DATA_W-1:0] m_data;
  logic              m_sop;
  logic              m_eop;

  modport master (
    output fifo_rd_en, m_valid, m_data, m_sop, m_eop,
    input  fifo_rd_data, fifo_rd_empty, fifo_rd_water_level, m_ready
  );

  modport slave (
    input  fifo_rd_en, m_valid, m_data, m_sop, m_eop,
    output fifo_rd_data, fifo_rd_empty, fifo_rd_water_level, m_ready
  );
endinterface

// File: rtl/afifo_rd_skid2.sv
// Two-entry registered output buffer: words with sop/eop tags in, valid/ready out.
module afifo_rd_skid2
  import afifo_ctrl_pkg::*;
#(
  parameter int DATA_W = DATA_W_DEF
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              wr_en,
  input  logic [DATA_W-1:0] wr_data,
  input  logic              wr_sop,
  input  logic              wr_eop,
  output logic              valid,
  input  logic              ready,
  output logic [DATA_W-1:0] data,
  output logic              sop,
  output logic              eop,
  output logic [1:0]        occ
);
  logic [DATA_W-1:0] data_q [2];
  logic [1:0]        sop_q, eop_q;
  logic              wr_ptr, rd_ptr;
  logic [1:0]        occ_q;
  logic              pop;

  assign valid = (occ_q != 2'd0);
  assign pop   = valid && ready;
  assign data  = data_q[rd_ptr];
  assign sop   = valid && sop_q[rd_ptr];
  assign eop   = valid && eop_q[rd_ptr];
  assign occ   = occ_q;

  // NOTE: sequential state uses <= so every register samples pre-edge values.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      // NOTE: the storage is reset as well, because m_data must read 0 out of reset.
      for (int i = 0; i < 2; i++) data_q[i] <= '0;
      sop_q  <= '0;
      eop_q  <= '0;
      wr_ptr <= 1'b0;
      rd_ptr <= 1'b0;
      occ_q  <= 2'd0;
    end else begin
      if (wr_en) begin
        data_q[wr_ptr] <= wr_data;
        sop_q[wr_ptr]  <= wr_sop;
        eop_q[wr_ptr]  <= wr_eop;
        wr_ptr         <= !wr_ptr;
      end
      if (pop) rd_ptr <= !rd_ptr;
      case ({wr_en, pop})
        2'b10:   occ_q <= occ_q + 2'd1;
        2'b01:   occ_q <= occ_q - 2'd1;
        default: occ_q <= occ_q;
      endcase
    end
  end
endmodule

// File: rtl/afifo_rd_burst_ctrl.sv
// Drains the async FIFO read side in fixed-length sop/eop framed bursts.
// Define AFIFO_RD_TIMEOUT_EN to flush a partial burst after TIMEOUT_CYC idle cycles.
module afifo_rd_burst_ctrl
  import afifo_ctrl_pkg::*;
#(
  parameter int DATA_W      = DATA_W_DEF,
  parameter int LVL_W       = LVL_W_DEF,
  parameter int BURST_LEN   = BURST_LEN_DEF,
  parameter int TIMEOUT_CYC = TIMEOUT_CYC_DEF
) (
  input  logic                  rd_clk,
  input  logic                  rd_rst_n,
  input  logic                  enable,
  afifo_rd_burst_ctrl_if.master bus,
  output logic                  busy,
  output logic                  burst_done
);
  localparam int              LEN_W    = $clog2(BURST_LEN + 1);
  localparam logic [LVL_W-1:0] FULL_LVL = LVL_W'(BURST_LEN);

  state_t           state, state_nxt;
  logic [LEN_W-1:0] len_q, reads_left, widx, start_len;
  logic             inflight, start, start_full, pop, credit, rd_en;
  logic [1:0]       occ;

  assign pop        = bus.m_valid && bus.m_ready;
  // Reserve a buffer slot for every word that is stored or still on its way back.
  assign credit     = (({1'b0, occ} + {2'b0, inflight}) - {2'b0, pop}) < 3'd2;
  assign rd_en      = (state == BURST) && !bus.fifo_rd_empty && (reads_left != '0) && credit;
  assign start_full = (state == IDLE) && enable && (bus.fifo_rd_water_level >= FULL_LVL);

`ifdef AFIFO_RD_TIMEOUT_EN
  localparam int IDLE_W = $clog2(TIMEOUT_CYC + 1);
  logic [IDLE_W-1:0] idle_cnt;
  logic              idle_qual, tmo_hit;

  assign idle_qual = (state == IDLE) && enable && !bus.fifo_rd_empty &&
                     (bus.fifo_rd_water_level < FULL_LVL);
  assign tmo_hit   = idle_qual && (idle_cnt == IDLE_W'(TIMEOUT_CYC)) &&
                     (bus.fifo_rd_water_level != '0);
  assign start     = start_full || tmo_hit;
  assign start_len = start_full ? LEN_W'(BURST_LEN) : LEN_W'(bus.fifo_rd_water_level);

  always_ff @(posedge rd_clk or negedge rd_rst_n) begin
    if (!rd_rst_n)                 idle_cnt <= '0;
    else if (idle_qual && !tmo_hit) idle_cnt <= idle_cnt + IDLE_W'(1);
    else                           idle_cnt <= '0;
  end
`else
  assign start     = start_full;
  assign start_len = LEN_W'(BURST_LEN);
`endif

  // NOTE: state_nxt is defaulted before the case so no path can infer a latch.
  always_comb begin
    state_nxt = state;
    case (state)
      IDLE:    if (start) state_nxt = BURST;
      BURST:   if (rd_en && (reads_left == LEN_W'(1))) state_nxt = DRAIN;
      DRAIN:   if (pop && bus.m_eop) state_nxt = IDLE;
      default: state_nxt = IDLE;
    endcase
  end

  always_ff @(posedge rd_clk or negedge rd_rst_n) begin
    if (!rd_rst_n) state <= IDLE;
    else           state <= state_nxt;
  end

  always_ff @(posedge rd_clk or negedge rd_rst_n) begin
    if (!rd_rst_n) begin
      len_q      <= '0;
      reads_left <= '0;
      widx       <= '0;
      inflight   <= 1'b0;
    end else begin
      inflight <= rd_en;
      if (start) begin
        len_q      <= start_len;
        reads_left <= start_len;
        widx       <= '0;
      end else begin
        if (rd_en)    reads_left <= reads_left - LEN_W'(1);
        if (inflight) widx       <= widx + LEN_W'(1);
      end
    end
  end

  assign bus.fifo_rd_en = rd_en;
  assign busy           = (state != IDLE);
  assign burst_done     = (state == DRAIN) && pop && bus.m_eop;

  afifo_rd_skid2 #(.DATA_W(DATA_W)) u_skid (
    .clk     (rd_clk),
    .rst_n   (rd_rst_n),
    .wr_en   (inflight),
    .wr_data (bus.fifo_rd_data),
    .wr_sop  (widx == '0),
    .wr_eop  (widx == (len_q - LEN_W'(1))),
    .valid   (bus.m_valid),
    .ready   (bus.m_ready),
    .data    (bus.m_data),
    .sop     (bus.m_sop),
    .eop     (bus.m_eop),
    .occ     (occ)
  );
endmodule
